// File: rtl/tob_publisher.sv
// Top-of-book publisher: detects changes in the best LEVELS buy/sell levels and
// serialises sequenced snapshot or heartbeat messages onto a byte stream.
module tob_publisher #(
  parameter int LEVELS           = 1,
  parameter int PRICE_W          = 32,
  parameter int QTY_W            = 32,
  parameter int HEARTBEAT_CYCLES = 250000
) (
  input  logic                                clkIn,
  input  logic                                rstIn,
  input  logic [LEVELS*(PRICE_W+QTY_W)-1:0]   buyLevelsIn,
  input  logic [LEVELS*(PRICE_W+QTY_W)-1:0]   sellLevelsIn,
  input  logic                                levelsValidIn,
  input  logic                                enIn,
  output logic [7:0]                          dataOut,
  output logic                                dataValidOut,
  input  logic                                dataReadyIn,
  output logic                                lastOut,
  output logic [15:0]                         seqNumOut,
  output logic [15:0]                         coalesceCntOut
);

  localparam int LVL_W      = PRICE_W + QTY_W;
  localparam int BODY_W     = 2 * LEVELS * LVL_W;
  localparam int BODY_BYTES = BODY_W / 8;
  localparam int IDX_W      = $clog2(BODY_BYTES);
  localparam int HB_W       = (HEARTBEAT_CYCLES > 2) ? $clog2(HEARTBEAT_CYCLES) : 1;

  localparam logic [IDX_W-1:0] BODY_LAST = IDX_W'(BODY_BYTES - 1);
  localparam logic [HB_W-1:0]  HB_LAST   = (HEARTBEAT_CYCLES > 0) ? HB_W'(HEARTBEAT_CYCLES - 1) : '0;

  localparam logic [7:0] TYPE_UPDATE    = 8'h42;
  localparam logic [7:0] TYPE_HEARTBEAT = 8'h48;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_BODY
  } state_t;

  state_t             r_state;
  logic [BODY_W-1:0]  r_latest;
  logic [BODY_W-1:0]  r_sent;
  logic [IDX_W-1:0]   r_idx;
  logic               r_hb_msg;
  logic [15:0]        r_seq;
  logic [15:0]        r_coal;
  logic [HB_W-1:0]    r_hb_cnt;
  logic [7:0]         r_data;
  logic               r_valid;
  logic               r_last;

  logic [BODY_W-1:0]  w_snapshot;
  logic               w_changed;
  logic               w_hb_due;
  logic               w_xfer;
  logic               w_coalesce;
  int                 w_sel;
  logic [7:0]         w_body_next;

  // Snapshot is held in wire order: byte 0 of the body sits in the top byte.
  always_comb begin
    w_snapshot = '0;
    for (int k = 0; k < LEVELS; k++) begin
      w_snapshot[BODY_W-1-k*LVL_W -: LVL_W]          = buyLevelsIn[k*LVL_W +: LVL_W];
      w_snapshot[BODY_W-1-(LEVELS+k)*LVL_W -: LVL_W] = sellLevelsIn[k*LVL_W +: LVL_W];
    end
  end

  assign w_changed = (r_latest != r_sent);
  assign w_hb_due  = (HEARTBEAT_CYCLES != 0) && (r_hb_cnt == HB_LAST);
  assign w_xfer    = r_valid && dataReadyIn;

  always_comb begin
    w_sel = 0;
    if (r_state == S_BODY) w_sel = int'(r_idx) + 1;
    w_body_next = 8'(r_sent >> (BODY_W - 8 * (w_sel + 1)));
  end

  assign w_coalesce = levelsValidIn && (w_snapshot != r_latest) && w_changed &&
                      ((r_state != S_IDLE) || !enIn);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_latest <= '0;
    end else if (levelsValidIn) begin
      r_latest <= w_snapshot;
    end
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_coal <= '0;
    end else if (w_coalesce && (r_coal != 16'hFFFF)) begin
      r_coal <= r_coal + 16'd1;
    end
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_state  <= S_IDLE;
      r_sent   <= '0;
      r_idx    <= '0;
      r_hb_msg <= 1'b0;
      r_seq    <= '0;
      r_hb_cnt <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enIn && w_changed) begin
            r_sent   <= r_latest;
            r_seq    <= r_seq + 16'd1;
            r_hb_msg <= 1'b0;
            r_hb_cnt <= '0;
            r_idx    <= '0;
            r_data   <= TYPE_UPDATE;
            r_valid  <= 1'b1;
            r_last   <= 1'b0;
            r_state  <= S_HDR;
          end else if (enIn && w_hb_due) begin
            r_seq    <= r_seq + 16'd1;
            r_hb_msg <= 1'b1;
            r_hb_cnt <= '0;
            r_idx    <= '0;
            r_data   <= TYPE_HEARTBEAT;
            r_valid  <= 1'b1;
            r_last   <= 1'b0;
            r_state  <= S_HDR;
          end else if (enIn) begin
            r_hb_cnt <= r_hb_cnt + 1'b1;
          end else begin
            r_hb_cnt <= '0;
          end
        end

        S_HDR: begin
          if (w_xfer) begin
            if (r_idx == '0) begin
              r_data <= r_seq[15:8];
              r_idx  <= IDX_W'(1);
            end else if (r_idx == IDX_W'(1)) begin
              r_data <= r_seq[7:0];
              r_last <= r_hb_msg;
              r_idx  <= IDX_W'(2);
            end else if (r_hb_msg) begin
              r_data  <= '0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_data  <= w_body_next;
              r_idx   <= '0;
              r_state <= S_BODY;
            end
          end
        end

        S_BODY: begin
          if (w_xfer) begin
            if (r_idx == BODY_LAST) begin
              r_data  <= '0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_data <= w_body_next;
              r_idx  <= r_idx + 1'b1;
              r_last <= ((r_idx + 1'b1) == BODY_LAST);
            end
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dataOut        = r_data;
  assign dataValidOut   = r_valid;
  assign lastOut        = r_last;
  assign seqNumOut      = r_seq;
  assign coalesceCntOut = r_coal;

endmodule

// File: tb/tb_tob_publisher.sv
// Scoreboard bench for tob_publisher: stimulus pushes expected bytes, a negedge
// monitor pops and compares every transferred byte.
module tb_tob_publisher;

  logic        clkIn;
  logic        rstIn;
  logic [63:0] buyLevelsIn;
  logic [63:0] sellLevelsIn;
  logic        levelsValidIn;
  logic        enIn;
  logic [7:0]  dataOut;
  logic        dataValidOut;
  logic        dataReadyIn;
  logic        lastOut;
  logic [15:0] seqNumOut;
  logic [15:0] coalesceCntOut;

  tob_publisher #(
    .LEVELS          (1),
    .PRICE_W         (32),
    .QTY_W           (32),
    .HEARTBEAT_CYCLES(16)
  ) dut (
    .clkIn         (clkIn),
    .rstIn         (rstIn),
    .buyLevelsIn   (buyLevelsIn),
    .sellLevelsIn  (sellLevelsIn),
    .levelsValidIn (levelsValidIn),
    .enIn          (enIn),
    .dataOut       (dataOut),
    .dataValidOut  (dataValidOut),
    .dataReadyIn   (dataReadyIn),
    .lastOut       (lastOut),
    .seqNumOut     (seqNumOut),
    .coalesceCntOut(coalesceCntOut)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  int          n_total = 0;
  int          n_bad   = 0;
  int          rx_count = 0;
  logic [8:0]  sb[$];
  logic [8:0]  mon_exp;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = '0;
  logic        prev_last  = 1'b0;
  int          rx_base;
  int          rise[$];
  logic        pv;
  logic [7:0]  exp1 [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [7:0] b, input logic last);
    sb.push_back({last, b});
  endtask

  task automatic push_update(input logic [15:0] seq, input logic [63:0] buy, input logic [63:0] sell);
    logic [127:0] body;
    body = {buy, sell};
    push(8'h42, 1'b0);
    push(seq[15:8], 1'b0);
    push(seq[7:0], 1'b0);
    for (int i = 0; i < 16; i++) push(body[127-8*i -: 8], i == 15);
  endtask

  task automatic push_hb(input logic [15:0] seq);
    push(8'h48, 1'b0);
    push(seq[15:8], 1'b0);
    push(seq[7:0], 1'b1);
  endtask

  task automatic send(input logic [63:0] buy, input logic [63:0] sell);
    @(posedge clkIn); #1;
    buyLevelsIn   = buy;
    sellLevelsIn  = sell;
    levelsValidIn = 1'b1;
    @(posedge clkIn); #1;
    levelsValidIn = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_count < n && k < budget) begin
      @(posedge clkIn); #1;
      k++;
    end
    check("rx_wait", 32'(rx_count >= n), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clkIn);
      k++;
    end
    #1;
    check("drain", sb.size(), 32'd0);
  endtask

  // Monitor: sampled on the falling edge, so a valid&&ready seen here transfers
  // at the next rising edge.
  always @(negedge clkIn) begin
    if (rstIn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold", {22'd0, dataValidOut, dataOut, lastOut}, {22'd0, 1'b1, prev_data, prev_last});
      if (dataValidOut && dataReadyIn) begin
        if (sb.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", dataOut);
        end else begin
          mon_exp = sb.pop_front();
          check("byte", {23'd0, lastOut, dataOut}, {23'd0, mon_exp});
        end
        rx_count++;
      end
      prev_stall = dataValidOut && !dataReadyIn;
      prev_data  = dataOut;
      prev_last  = lastOut;
    end
  end

  initial begin
    rstIn = 1'b1; enIn = 1'b0; dataReadyIn = 1'b1; levelsValidIn = 1'b0;
    buyLevelsIn = '0; sellLevelsIn = '0;
    repeat (3) @(posedge clkIn); #1;
    check("rst_data",  dataOut, 8'h00);
    check("rst_valid", dataValidOut, 1'b0);
    check("rst_last",  lastOut, 1'b0);
    check("rst_seq",   seqNumOut, 16'h0000);
    check("rst_coal",  coalesceCntOut, 16'h0000);
    rstIn = 1'b0;
    @(posedge clkIn); #1;

    // Single update with hand-computed bytes and latency.
    exp1 = '{8'h42, 8'h00, 8'h01, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h64,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 19; i++) push(exp1[i], i == 18);
    rx_base = rx_count;
    enIn = 1'b1;
    send(64'h00001234_00000064, 64'h0);
    check("lat_t1_valid", dataValidOut, 1'b0);
    @(posedge clkIn); #1;
    check("lat_t2_valid", dataValidOut, 1'b1);
    check("lat_t2_type",  dataOut, 8'h42);
    check("seq_at_start", seqNumOut, 16'h0001);
    wait_drain(100);
    enIn = 1'b0;
    check("t1_count", rx_count - rx_base, 32'd19);

    // Backpressure on byte 4.
    rx_base = rx_count;
    enIn = 1'b1;
    push_update(16'h0002, 64'h00005678_000000C8, 64'h00009ABC_00000010);
    send(64'h00005678_000000C8, 64'h00009ABC_00000010);
    wait_rx(rx_base + 3, 50);
    dataReadyIn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clkIn); #1;
      check("bp_valid", dataValidOut, 1'b1);
      check("bp_byte4", dataOut, 8'h00);
    end
    dataReadyIn = 1'b1;
    wait_drain(100);
    enIn = 1'b0;
    check("bp_count", rx_count - rx_base, 32'd19);
    check("bp_seq", seqNumOut, 16'h0002);

    // Coalescing: A, B, C during message X; only C follows.
    rx_base = rx_count;
    enIn = 1'b1;
    push_update(16'h0003, 64'h11111111_22222222, 64'h33333333_44444444);
    push_update(16'h0004, 64'h0000CCCC_0000000C, 64'h0000DDDD_0000000D);
    send(64'h11111111_22222222, 64'h33333333_44444444);
    wait_rx(rx_base + 2, 50);
    send(64'h0000AAAA_0000000A, 64'h0);
    send(64'h0000BBBB_0000000B, 64'h0);
    send(64'h0000CCCC_0000000C, 64'h0000DDDD_0000000D);
    wait_drain(200);
    enIn = 1'b0;
    check("coal_cnt", coalesceCntOut, 16'd2);
    check("coal_seq", seqNumOut, 16'h0004);
    check("coal_count", rx_count - rx_base, 32'd38);

    // Heartbeats after a fresh reset, then update wins on the expiry cycle.
    rstIn = 1'b1;
    @(posedge clkIn); #1;
    rstIn = 1'b0;
    check("hb_rst_coal", coalesceCntOut, 16'd0);
    push_hb(16'h0001);
    push_hb(16'h0002);
    push_update(16'h0003, 64'h0000ABCD_00000001, 64'h0);
    enIn = 1'b1;
    pv = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clkIn); #1;
      if (k == 52) begin
        buyLevelsIn   = 64'h0000ABCD_00000001;
        sellLevelsIn  = 64'h0;
        levelsValidIn = 1'b1;
      end
      if (k == 53) levelsValidIn = 1'b0;
      if (dataValidOut && !pv) rise.push_back(k);
      if (k == 54) check("prio_type", dataOut, 8'h42);
      pv = dataValidOut;
    end
    check("hb_rise_n", rise.size(), 32'd3);
    if (rise.size() == 3) begin
      check("hb1_start", rise[0], 32'd16);
      check("hb2_start", rise[1], 32'd35);
      check("prio_start", rise[2], 32'd54);
    end
    wait_drain(100);
    enIn = 1'b0;

    // Reset during byte 7, then republish starting again at seq 1.
    rx_base = rx_count;
    enIn = 1'b1;
    push_update(16'h0004, 64'hDEADBEEF_00000007, 64'hCAFEF00D_00000009);
    send(64'hDEADBEEF_00000007, 64'hCAFEF00D_00000009);
    wait_rx(rx_base + 6, 50);
    check("pre_rst_byte7", dataOut, 8'hEF);
    rstIn = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_data",  dataOut, 8'h00);
    check("mid_rst_valid", dataValidOut, 1'b0);
    check("mid_rst_last",  lastOut, 1'b0);
    check("mid_rst_seq",   seqNumOut, 16'h0000);
    check("mid_rst_coal",  coalesceCntOut, 16'h0000);
    @(posedge clkIn); #1;
    rstIn = 1'b0;
    push_update(16'h0001, 64'hDEADBEEF_00000007, 64'hCAFEF00D_00000009);
    send(64'hDEADBEEF_00000007, 64'hCAFEF00D_00000009);
    wait_drain(100);
    enIn = 1'b0;
    check("post_rst_seq", seqNumOut, 16'h0001);

    // Sequence wrap from 0xFFFF.
    @(posedge clkIn); #1;
    force dut.r_seq = 16'hFFFF;
    @(posedge clkIn); #1;
    check("seq_forced", seqNumOut, 16'hFFFF);
    release dut.r_seq;
    enIn = 1'b1;
    push_update(16'h0000, 64'h01020304_05060708, 64'h090A0B0C_0D0E0F10);
    send(64'h01020304_05060708, 64'h090A0B0C_0D0E0F10);
    wait_drain(100);
    enIn = 1'b0;
    check("wrap_seq", seqNumOut, 16'h0000);

    repeat (3) @(posedge clkIn); #1;
    check("final_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
